// File: rtl/mips_defs.sv
// ---------------------------------------------------------------------------
// mips_defs
// Shared MIPS definitions for the pipeline stages: opcode / funct encodings,
// the link register index, the default reset PC, the writeback result-source
// enumeration and the sub-word load extension helper.
// No ports (package).
// ---------------------------------------------------------------------------
package mips_defs;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [4:0]  REG_RA           = 5'd31;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_MFHI = 6'h10;
    localparam logic [5:0] FN_MTHI = 6'h11;
    localparam logic [5:0] FN_MFLO = 6'h12;
    localparam logic [5:0] FN_MTLO = 6'h13;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    // Where the W-stage result comes from
    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_HI,
        SRC_LO,
        SRC_LINK,
        SRC_MEM
    } wb_src_e;

    // Extract and extend the addressed byte/half of a loaded word.
    // Byte lanes are little-endian; half selection uses addr[1] only.
    function automatic logic [31:0] load_extend(input logic [5:0]  op,
                                                input logic [1:0]  off,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (op)
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LBU:  r = {24'h0, b};
            OP_LH:   r = {{16{h[15]}}, h};
            OP_LHU:  r = {16'h0, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/wb_stage_if.sv
// ---------------------------------------------------------------------------
// wb_stage_if
// MW pipeline-register bundle carried into the writeback stage.
//   readdata_w : aligned word read by M stage
//   aluout_w   : ALU result / effective address
//   pc_w       : PC of the W-stage instruction
//   instr_w    : W-stage instruction word (0 = bubble)
//   hi_w/lo_w  : HI/LO values carried to W
// master: the MW register (driver); slave: the writeback stage.
// ---------------------------------------------------------------------------
interface wb_stage_if;
    logic [31:0] readdata_w;
    logic [31:0] aluout_w;
    logic [31:0] pc_w;
    logic [31:0] instr_w;
    logic [31:0] hi_w;
    logic [31:0] lo_w;

    modport master (
        output readdata_w, aluout_w, pc_w, instr_w, hi_w, lo_w
    );

    modport slave (
        input readdata_w, aluout_w, pc_w, instr_w, hi_w, lo_w
    );
endinterface

// File: rtl/grf.sv
// ---------------------------------------------------------------------------
// grf
// 32x32 general register file, 2 combinational read ports, 1 write port.
// $0 is hard-wired to zero; a write in the current cycle is visible on the
// read ports in the same cycle (write-through bypass).
//   clk, reset          : clock, synchronous active-high reset (clears all)
//   i_we/i_waddr/i_wdata: write port, ignored while reset is high
//   i_raddr_a/_b        : read addresses
//   o_rdata_a/_b        : read data
// ---------------------------------------------------------------------------
module grf (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata,
    input  logic [4:0]  i_raddr_a,
    input  logic [4:0]  i_raddr_b,
    output logic [31:0] o_rdata_a,
    output logic [31:0] o_rdata_b
);
    import mips_defs::*;

    logic [31:0] r_regs [31:1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != 5'd0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Bypass uses the raw write enable: the value being written this cycle
    // is forwarded even when reset will drop it at the edge.
    always_comb begin
        if (i_raddr_a == 5'd0)
            o_rdata_a = '0;
        else if (i_we && (i_raddr_a == i_waddr))
            o_rdata_a = i_wdata;
        else
            o_rdata_a = r_regs[i_raddr_a];
    end

    always_comb begin
        if (i_raddr_b == 5'd0)
            o_rdata_b = '0;
        else if (i_we && (i_raddr_b == i_waddr))
            o_rdata_b = i_wdata;
        else
            o_rdata_b = r_regs[i_raddr_b];
    end

endmodule

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage
// Writeback stage of the 5-stage MIPS pipeline. Decodes the W-stage
// instruction, selects/extends the result, writes the register file, serves
// D-stage reads with write-through bypass, and counts retired instructions.
//   clk, reset     : clock, synchronous active-high reset
//   mw             : MW pipeline register bundle (slave)
//   rs_addr/rt_addr: D-stage read addresses
//   rs_data/rt_data: D-stage read data (combinational, bypassed)
//   wb_we/addr/data: W-stage write tap for hazard forwarding (zero if no write)
//   trace_pc       : pc_w when a register is written, else RESET_PC
//   retire_cnt     : number of retired non-bubble instructions (wraps)
// ---------------------------------------------------------------------------
module wb_stage
    import mips_defs::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    wb_stage_if.slave     mw,
    input  logic [4:0]    rs_addr,
    input  logic [4:0]    rt_addr,
    output logic [31:0]   rs_data,
    output logic [31:0]   rt_data,
    output logic          wb_we,
    output logic [4:0]    wb_addr,
    output logic [31:0]   wb_data,
    output logic [31:0]   trace_pc,
    output logic [31:0]   retire_cnt
);

    logic [5:0]  w_op;
    logic [5:0]  w_fn;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    wb_src_e     w_src;
    logic [4:0]  w_dest;
    logic [31:0] w_result;
    logic [31:0] r_retire_cnt;
    logic        w_unused_bits;

    assign w_op = mw.instr_w[31:26];
    assign w_fn = mw.instr_w[5:0];
    assign w_rt = mw.instr_w[20:16];
    assign w_rd = mw.instr_w[15:11];

    // rs and shamt fields play no part in writeback
    assign w_unused_bits = ^{mw.instr_w[25:21], mw.instr_w[10:6]};

    // Destination and result-source decode
    always_comb begin
        w_src  = SRC_NONE;
        w_dest = 5'd0;
        if (w_op == OP_RTYPE) begin
            case (w_fn)
                FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR,
                FN_NOR, FN_SLT, FN_SLTU, FN_SLL, FN_SRL, FN_SRA, FN_SLLV,
                FN_SRLV, FN_SRAV: begin
                    w_src  = SRC_ALU;
                    w_dest = w_rd;
                end
                FN_MFHI: begin
                    w_src  = SRC_HI;
                    w_dest = w_rd;
                end
                FN_MFLO: begin
                    w_src  = SRC_LO;
                    w_dest = w_rd;
                end
                FN_JALR: begin
                    w_src  = SRC_LINK;
                    w_dest = w_rd;
                end
                default: ;
            endcase
        end else begin
            case (w_op)
                OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
                OP_SLTI, OP_SLTIU: begin
                    w_src  = SRC_ALU;
                    w_dest = w_rt;
                end
                OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU: begin
                    w_src  = SRC_MEM;
                    w_dest = w_rt;
                end
                OP_JAL: begin
                    w_src  = SRC_LINK;
                    w_dest = REG_RA;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (w_src)
            SRC_ALU:  w_result = mw.aluout_w;
            SRC_HI:   w_result = mw.hi_w;
            SRC_LO:   w_result = mw.lo_w;
            SRC_LINK: w_result = mw.pc_w + 32'd8;
            SRC_MEM:  w_result = load_extend(w_op, mw.aluout_w[1:0], mw.readdata_w);
            default:  w_result = '0;
        endcase
    end

    // Writes to $0 are squashed here so the forwarding tap never advertises them
    assign wb_we    = (w_src != SRC_NONE) && (w_dest != 5'd0);
    assign wb_addr  = wb_we ? w_dest   : 5'd0;
    assign wb_data  = wb_we ? w_result : 32'd0;
    assign trace_pc = (!reset && wb_we) ? mw.pc_w : RESET_PC;

    grf u_grf (
        .clk       (clk),
        .reset     (reset),
        .i_we      (wb_we),
        .i_waddr   (wb_addr),
        .i_wdata   (wb_data),
        .i_raddr_a (rs_addr),
        .i_raddr_b (rt_addr),
        .o_rdata_a (rs_data),
        .o_rdata_b (rt_data)
    );

    always_ff @(posedge clk) begin
        if (reset)
            r_retire_cnt <= '0;
        else if (mw.instr_w != 32'd0)
            r_retire_cnt <= r_retire_cnt + 32'd1;
    end

    assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

    localparam logic [31:0] RPC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs_addr, rt_addr;
    logic [31:0] rs_data, rt_data, wb_data, trace_pc, retire_cnt;
    logic        wb_we;
    logic [4:0]  wb_addr;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;

    logic [5:0] fn_tab [26] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08,
                                6'h09, 6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19,
                                6'h1a, 6'h1b, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                                6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};
    logic [5:0] op_tab [22] = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0a,
                                6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h20, 6'h21,
                                6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2b, 6'h01,
                                6'h06};

    wb_stage_if mw ();

    wb_stage #(.RESET_PC(RPC)) dut (
        .clk        (clk),
        .reset      (reset),
        .mw         (mw),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .trace_pc   (trace_pc),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    // Reference: what the W stage architecturally writes for one instruction
    function automatic void ref_wb(input logic [31:0] ins, input logic [31:0] rdat,
                                   input logic [31:0] alu, input logic [31:0] pc,
                                   input logic [31:0] hi, input logic [31:0] lo,
                                   output logic we, output logic [4:0] a,
                                   output logic [31:0] d);
        logic [5:0]  op = ins[31:26];
        logic [5:0]  fn = ins[5:0];
        logic [4:0]  dst = 5'd0;
        logic [31:0] v = 32'd0;
        logic [31:0] sh;
        bit          wr = 0;
        if (op == 6'h00) begin
            if (fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                           6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07}) begin
                wr = 1; dst = ins[15:11]; v = alu;
            end else if (fn == 6'h10) begin
                wr = 1; dst = ins[15:11]; v = hi;
            end else if (fn == 6'h12) begin
                wr = 1; dst = ins[15:11]; v = lo;
            end else if (fn == 6'h09) begin
                wr = 1; dst = ins[15:11]; v = pc + 8;
            end
        end else if (op >= 6'h08 && op <= 6'h0f) begin
            wr = 1; dst = ins[20:16]; v = alu;
        end else if (op == 6'h23) begin
            wr = 1; dst = ins[20:16]; v = rdat;
        end else if (op == 6'h20 || op == 6'h24) begin
            sh = rdat >> (8 * alu[1:0]);
            v = {24'h0, sh[7:0]};
            if (op == 6'h20 && v >= 128) v = v - 256;
            wr = 1; dst = ins[20:16];
        end else if (op == 6'h21 || op == 6'h25) begin
            sh = rdat >> (16 * alu[1]);
            v = {16'h0, sh[15:0]};
            if (op == 6'h21 && v >= 32768) v = v - 65536;
            wr = 1; dst = ins[20:16];
        end else if (op == 6'h03) begin
            wr = 1; dst = 5'd31; v = pc + 8;
        end
        we = wr && (dst != 0);
        a  = we ? dst : 5'd0;
        d  = we ? v : 32'd0;
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] addr);
        logic we; logic [4:0] a; logic [31:0] d;
        ref_wb(mw.instr_w, mw.readdata_w, mw.aluout_w, mw.pc_w, mw.hi_w, mw.lo_w, we, a, d);
        if (addr == 0) return 32'd0;
        if (we && addr == a) return d;
        return m_regs[addr];
    endfunction

    // Commit the model with the inputs present at the coming edge, then advance
    task automatic tick();
        logic we; logic [4:0] a; logic [31:0] d;
        ref_wb(mw.instr_w, mw.readdata_w, mw.aluout_w, mw.pc_w, mw.hi_w, mw.lo_w, we, a, d);
        if (reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_cnt = 32'd0;
        end else begin
            if (we) m_regs[a] = d;
            if (mw.instr_w != 0) m_cnt = m_cnt + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_w(input logic [31:0] ins, input logic [31:0] rdat,
                         input logic [31:0] alu, input logic [31:0] pc,
                         input logic [31:0] hi, input logic [31:0] lo);
        mw.instr_w = ins; mw.readdata_w = rdat; mw.aluout_w = alu;
        mw.pc_w = pc; mw.hi_w = hi; mw.lo_w = lo;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; rs_addr = 5'd5; rt_addr = 5'd31;
        set_w(0, 0, 0, 0, 0, 0);
        tick(); tick();
        checks++; if (trace_pc !== RPC) begin errors++; $display("FAIL reset_trace_pc got %h want %h", trace_pc, RPC); end
        reset = 1'b0; #1;
        checks++; if (retire_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %h want 0", retire_cnt); end
        checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", wb_we); end
        checks++; if (rs_data !== 32'd0) begin errors++; $display("FAIL reset_rs got %h want 0", rs_data); end
        checks++; if (rt_data !== 32'd0) begin errors++; $display("FAIL reset_rt got %h want 0", rt_data); end
    endtask

    task automatic test_alu();
        set_w(32'h0022_1821, 0, 32'h1234_5678, 32'h0000_3004, 0, 0);
        checks++; if (wb_we !== 1'b1) begin errors++; $display("FAIL addu_we got %b want 1", wb_we); end
        checks++; if (wb_addr !== 5'd3) begin errors++; $display("FAIL addu_addr got %0d want 3", wb_addr); end
        checks++; if (wb_data !== 32'h1234_5678) begin errors++; $display("FAIL addu_data got %h want 12345678", wb_data); end
        checks++; if (trace_pc !== 32'h0000_3004) begin errors++; $display("FAIL addu_trace got %h want 00003004", trace_pc); end
        tick();
        rs_addr = 5'd3;
        set_w(0, 0, 0, 0, 0, 0);
        checks++; if (rs_data !== 32'h1234_5678) begin errors++; $display("FAIL addu_read got %h want 12345678", rs_data); end
    endtask

    task automatic test_loads();
        set_w(32'h8004_0001, 32'h0000_80FF, 32'd1, 32'h0000_3008, 0, 0);
        checks++; if (wb_data !== 32'hFFFF_FF80 || wb_addr !== 5'd4) begin errors++; $display("FAIL lb got %h@%0d want ffffff80@4", wb_data, wb_addr); end
        tick();
        set_w(32'h9004_0001, 32'h0000_80FF, 32'd1, 32'h0000_300C, 0, 0);
        checks++; if (wb_data !== 32'h0000_0080) begin errors++; $display("FAIL lbu got %h want 00000080", wb_data); end
        tick();
        set_w(32'h8404_0002, 32'h8001_0000, 32'd2, 32'h0000_3010, 0, 0);
        checks++; if (wb_data !== 32'hFFFF_8001) begin errors++; $display("FAIL lh got %h want ffff8001", wb_data); end
        tick();
        rs_addr = 5'd4;
        set_w(0, 0, 0, 0, 0, 0);
        checks++; if (rs_data !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_read got %h want ffff8001", rs_data); end
    endtask

    task automatic test_jal_mfhi();
        set_w(32'h0C00_0C10, 0, 0, 32'h0000_3010, 0, 0);
        checks++; if (wb_addr !== 5'd31 || wb_data !== 32'h0000_3018) begin errors++; $display("FAIL jal got %h@%0d want 00003018@31", wb_data, wb_addr); end
        tick();
        set_w(32'h0000_2810, 0, 0, 32'h0000_3014, 32'hDEAD_BEEF, 32'h1111_2222);
        checks++; if (wb_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mfhi got %h want deadbeef", wb_data); end
        tick();
        rs_addr = 5'd5; rt_addr = 5'd31;
        set_w(0, 0, 0, 0, 0, 0);
        checks++; if (rs_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mfhi_read got %h want deadbeef", rs_data); end
        checks++; if (rt_data !== 32'h0000_3018) begin errors++; $display("FAIL jal_read got %h want 00003018", rt_data); end
    endtask

    task automatic test_no_write();
        logic [31:0] ins_tab [4] = '{32'h3400_0005, 32'hAC03_0000, 32'h1000_0001, 32'h0000_0000};
        rs_addr = 5'd0; rt_addr = 5'd3;
        for (int i = 0; i < 4; i++) begin
            set_w(ins_tab[i], 32'hCAFE_F00D, 32'd5, 32'h0000_3020, 0, 0);
            checks++; if (wb_we !== 1'b0 || wb_addr !== 5'd0 || wb_data !== 32'd0)
                begin errors++; $display("FAIL nowrite_%0d got we=%b addr=%0d data=%h want 0/0/0", i, wb_we, wb_addr, wb_data); end
            checks++; if (trace_pc !== RPC) begin errors++; $display("FAIL nowrite_trace_%0d got %h want %h", i, trace_pc, RPC); end
            checks++; if (rs_data !== 32'd0) begin errors++; $display("FAIL r0_read_%0d got %h want 0", i, rs_data); end
            tick();
        end
        checks++; if (rt_data !== 32'h1234_5678) begin errors++; $display("FAIL nowrite_r3 got %h want 12345678", rt_data); end
    endtask

    task automatic test_bypass();
        rs_addr = 5'd7; rt_addr = 5'd7;
        set_w(32'h3407_A5A5, 0, 32'hA5A5_A5A5, 32'h0000_3030, 0, 0);
        checks++; if (rs_data !== 32'hA5A5_A5A5) begin errors++; $display("FAIL bypass_rs got %h want a5a5a5a5", rs_data); end
        checks++; if (rt_data !== 32'hA5A5_A5A5) begin errors++; $display("FAIL bypass_rt got %h want a5a5a5a5", rt_data); end
        tick();
    endtask

    task automatic test_counter_reset();
        logic [31:0] seq [7] = '{32'h0022_1821, 32'h0, 32'hAC03_0000, 32'h1000_0001,
                                 32'h0, 32'h3408_0001, 32'h0000_2812};
        reset = 1'b1; set_w(0, 0, 0, 0, 0, 0); tick(); reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            set_w(seq[i], 32'h0, 32'h0000_0042, 32'h0000_3040, 0, 0);
            tick();
        end
        checks++; if (retire_cnt !== 32'd5) begin errors++; $display("FAIL retire_cnt got %0d want 5", retire_cnt); end
        reset = 1'b1; rs_addr = 5'd3;
        set_w(32'h0022_1821, 0, 32'h7777_7777, 32'h0000_3050, 0, 0);
        checks++; if (trace_pc !== RPC) begin errors++; $display("FAIL reset_pending_trace got %h want %h", trace_pc, RPC); end
        tick();
        reset = 1'b0;
        set_w(0, 0, 0, 0, 0, 0);
        checks++; if (rs_data !== 32'd0) begin errors++; $display("FAIL reset_drop_r3 got %h want 0", rs_data); end
        checks++; if (retire_cnt !== 32'd0) begin errors++; $display("FAIL reset_clear_cnt got %0d want 0", retire_cnt); end
    endtask

    function automatic logic [31:0] gen_instr();
        int k = $urandom_range(0, 9);
        if (k == 0) return 32'd0;
        if (k == 1) return $urandom();
        if (k <= 5) return {6'h00, 15'($urandom()), 5'($urandom()), fn_tab[$urandom_range(0, 25)]};
        return {op_tab[$urandom_range(0, 21)], 26'($urandom())};
    endfunction

    task automatic test_random();
        logic        we;
        logic [4:0]  a;
        logic [31:0] d, ins;
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 99) < 3);
            ins = gen_instr();
            rs_addr = ($urandom_range(0, 3) == 0) ? ins[15:11] : 5'($urandom());
            rt_addr = ($urandom_range(0, 3) == 0) ? ins[20:16] : 5'($urandom());
            set_w(ins, $urandom(), $urandom(), $urandom() & 32'hFFFF_FFFC, $urandom(), $urandom());
            ref_wb(mw.instr_w, mw.readdata_w, mw.aluout_w, mw.pc_w, mw.hi_w, mw.lo_w, we, a, d);
            checks++; if (wb_we !== we || wb_addr !== a || wb_data !== d)
                begin errors++; $display("FAIL rnd_wb_%0d instr %h got %b/%0d/%h want %b/%0d/%h", n, ins, wb_we, wb_addr, wb_data, we, a, d); end
            checks++; if (rs_data !== ref_read(rs_addr))
                begin errors++; $display("FAIL rnd_rs_%0d addr %0d got %h want %h", n, rs_addr, rs_data, ref_read(rs_addr)); end
            checks++; if (rt_data !== ref_read(rt_addr))
                begin errors++; $display("FAIL rnd_rt_%0d addr %0d got %h want %h", n, rt_addr, rt_data, ref_read(rt_addr)); end
            checks++; if (trace_pc !== ((we && !reset) ? mw.pc_w : RPC))
                begin errors++; $display("FAIL rnd_trace_%0d got %h want %h", n, trace_pc, (we && !reset) ? mw.pc_w : RPC); end
            checks++; if (retire_cnt !== m_cnt)
                begin errors++; $display("FAIL rnd_cnt_%0d got %0d want %0d", n, retire_cnt, m_cnt); end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        rs_addr = 5'd0;
        rt_addr = 5'd0;
        set_w(0, 0, 0, 0, 0, 0);
        test_reset();
        test_alu();
        test_loads();
        test_jal_mfhi();
        test_no_write();
        test_bypass();
        test_counter_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
